// File: rtl/fpu_seq.sv
// Multicycle sequencer for the shared FP32/FP16 datapath.
// Steps unpack, align, exec, normalize, round and writeback.
module fpu_seq #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic       half,
    input  logic       special,
    input  logic       norm_done,
    output logic       busy,
    output logic       done,
    output logic       unpack_en,
    output logic       align_en,
    output logic       op_en,
    output logic       norm_en,
    output logic       round_en,
    output logic       res_we,
    output logic       uf,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        EXEC   = 3'd3,
        NORM   = 3'd4,
        ROUND  = 3'd5,
        WB     = 3'd6,
        BAD    = 3'd7
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     next;
    logic [3:0] mul_cnt;
    logic [4:0] norm_cnt;
    logic       op_q;
    logic       half_q;
    logic       mul_last;
    logic       norm_limit;

    assign mul_last   = (mul_cnt == MUL_LAST);
    // Last permitted shift: 24 for FP32, 11 for FP16
    assign norm_limit = (norm_cnt == (half_q ? 5'd10 : 5'd23));
    assign state_o    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mul_cnt  <= 4'd0;
            norm_cnt <= 5'd0;
            op_q     <= 1'b0;
            half_q   <= 1'b0;
            uf       <= 1'b0;
        end else begin
            state    <= next;
            mul_cnt  <= (state == EXEC) ? mul_cnt + 4'd1 : 4'd0;
            norm_cnt <= (state == NORM) ? norm_cnt + 5'd1 : 5'd0;
            if (state == IDLE && start) begin
                op_q   <= op;
                half_q <= half;
                uf     <= 1'b0;
            end
            if (state == NORM && !norm_done && norm_limit)
                uf <= 1'b1;
        end
    end

    always_comb begin
        next      = state;
        busy      = 1'b1;
        done      = 1'b0;
        unpack_en = 1'b0;
        align_en  = 1'b0;
        op_en     = 1'b0;
        norm_en   = 1'b0;
        round_en  = 1'b0;
        res_we    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    next = UNPACK;
            end
            UNPACK: begin
                unpack_en = 1'b1;
                if (special)
                    next = WB;
                else if (!op_q)
                    next = ALIGN;
                else
                    next = EXEC;
            end
            ALIGN: begin
                align_en = 1'b1;
                next     = EXEC;
            end
            EXEC: begin
                op_en = 1'b1;
                if (!op_q || mul_last)
                    next = NORM;
            end
            NORM: begin
                norm_en = 1'b1;
                if (norm_done || norm_limit)
                    next = ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                next     = WB;
            end
            WB: begin
                done   = 1'b1;
                res_we = 1'b1;
                next   = IDLE;
            end
            default: begin
                busy = 1'b0;
                next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Randomized bench for fpu_seq against a per-operation
// expected-state-trace model.
module tb_fpu_seq;

    localparam int M = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic       half = 1'b0;
    logic       special = 1'b0;
    logic       norm_done = 1'b0;
    logic       busy, done, res_we, uf;
    logic       unpack_en, align_en, op_en, norm_en, round_en;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail = 0;
    logic uf_model = 1'b0;

    fpu_seq #(.MUL_CYCLES(M)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .half(half), .special(special), .norm_done(norm_done),
        .busy(busy), .done(done), .unpack_en(unpack_en),
        .align_en(align_en), .op_en(op_en), .norm_en(norm_en),
        .round_en(round_en), .res_we(res_we), .uf(uf),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] en_of(input int s);
        case (s)
            1: return 5'b10000;
            2: return 5'b01000;
            3: return 5'b00100;
            4: return 5'b00010;
            5: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] en_now();
        return {unpack_en, align_en, op_en, norm_en, round_en};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            op        = 1'($urandom);
            half      = 1'($urandom);
            special   = 1'($urandom);
            norm_done = 1'($urandom);
            @(negedge clk);
            check("idle_state", 32'(state_o), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_uf", 32'(uf), 32'(uf_model));
            @(posedge clk); #1;
        end
    endtask

    // k: NORM cycle (1-based) on which norm_done rises; 0 = never
    task automatic run_op(input logic o, input logic h,
                          input logic sp, input int k_in);
        int q[$];
        int lim, k, n, lat, exp_lat, j;
        logic ufx;
        lim = h ? 11 : 24;
        k = (k_in > lim) ? 0 : k_in;
        n = (k == 0) ? lim : k;
        ufx = !sp && (k == 0);
        q.push_back(1);
        if (sp) begin
            exp_lat = 2;
        end else begin
            if (!o) q.push_back(2);
            for (int i = 0; i < (o ? M : 1); i++) q.push_back(3);
            for (int i = 0; i < n; i++) q.push_back(4);
            q.push_back(5);
            exp_lat = o ? 3 + M + n : 5 + n;
        end
        q.push_back(6);
        start     = 1'b1;
        op        = o;
        half      = h;
        special   = 1'($urandom);
        norm_done = 1'($urandom);
        @(negedge clk);
        check("start_state", 32'(state_o), 0);
        check("start_busy", 32'(busy), 0);
        check("start_uf", 32'(uf), 32'(uf_model));
        @(posedge clk); #1;
        uf_model = 1'b0;
        lat = -1;
        j = 0;
        for (int i = 0; i < q.size(); i++) begin
            start = 1'($urandom);
            op    = 1'($urandom);
            half  = 1'($urandom);
            special = (q[i] == 1) ? sp : 1'($urandom);
            if (q[i] == 4) begin
                j++;
                norm_done = (k != 0 && j == k);
            end else begin
                norm_done = 1'($urandom);
            end
            if (q[i] == 5) uf_model = ufx;
            @(negedge clk);
            check("state", 32'(state_o), 32'(q[i]));
            check("busy", 32'(busy), 1);
            check("enables", 32'(en_now()), 32'(en_of(q[i])));
            check("done", 32'(done), 32'(q[i] == 6));
            check("res_we", 32'(res_we), 32'(q[i] == 6));
            check("uf", 32'(uf), 32'(uf_model));
            if (done && lat < 0) lat = i + 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_o), 0);
        check("rst_outs", 32'({busy, done, res_we, uf, en_now()}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(2);

        run_op(1'b0, 1'b0, 1'b0, 1);
        run_op(1'b1, 1'b1, 1'b0, 2);
        run_op(1'b0, 1'b0, 1'b1, 1);
        run_op(1'b0, 1'b0, 1'b0, 0);
        idle_cycles(3);
        run_op(1'b1, 1'b1, 1'b0, 0);
        run_op(1'b0, 1'b1, 1'b0, 11);
        run_op(1'b1, 1'b0, 1'b0, 24);
        run_op(1'b1, 1'b0, 1'b0, 3);
        run_op(1'b1, 1'b0, 1'b0, 1);

        for (int t = 0; t < 40; t++) begin
            run_op(1'($urandom), 1'($urandom),
                   ($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 27)));
            if ($urandom_range(0, 1) == 1)
                idle_cycles(int'($urandom_range(1, 3)));
        end

        start = 1'b1; op = 1'b0; half = 1'b0;
        special = 1'b0; norm_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_norm", 32'(state_o), 4);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_state", 32'(state_o), 0);
        check("async_outs", 32'({busy, done, res_we, uf, en_now()}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        uf_model = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_we", 32'(res_we), 0);
            check("post_rst_state", 32'(state_o), 0);
            @(posedge clk); #1;
        end
        run_op(1'b0, 1'b1, 1'b0, 4);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
